// File: rtl/bias_ctrl.sv
// bias_ctrl: configuration and sequencing for the bias_add output stage.
// Takes a per-frame config (channels, pixels per channel), loads one bias
// per channel, then streams channel-major data to bias_add paired with the
// matching bias. dn_valid/dn_last line up with bias_add's registered sum.
//
// state  | meaning
// S_IDLE | waiting for a frame configuration (cfg_ready high)
// S_LOAD | accepting one bias word per channel (bias_ready high)
// S_RUN  | streaming feature data to bias_add (up_ready high)
module bias_ctrl #(
  parameter int NUM_WIDTH = 16,
  parameter int DEPTH_NB  = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  input  logic [DEPTH_NB:0]    cfg_chans,
  input  logic [CNT_WIDTH-1:0] cfg_pixels,
  output logic                 cfg_ready,
  output logic                 cfg_err,
  input  logic                 bias_valid,
  input  logic [NUM_WIDTH-1:0] bias_data,
  output logic                 bias_ready,
  input  logic                 up_valid,
  input  logic [NUM_WIDTH-1:0] up_data,
  output logic                 up_ready,
  output logic [NUM_WIDTH-1:0] add_bias,
  output logic [NUM_WIDTH-1:0] add_data,
  output logic                 dn_valid,
  output logic                 dn_last,
  output logic                 busy
);

  localparam int NUM_CH = 1 << DEPTH_NB;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [DEPTH_NB-1:0]  chan_last_q, chan_last_d;
  logic [CNT_WIDTH-1:0] pix_last_q, pix_last_d;
  logic [DEPTH_NB-1:0]  load_idx_q, load_idx_d;
  logic [DEPTH_NB-1:0]  chan_idx_q, chan_idx_d;
  logic [CNT_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
  logic                 cfg_err_q, cfg_err_d;

  logic [NUM_WIDTH-1:0] bias_mem [NUM_CH];

  logic [NUM_WIDTH-1:0] add_data_q, add_bias_q;
  logic                 v1_q, l1_q;
  logic                 dn_valid_q, dn_last_q;

  logic cfg_legal, bias_fire, up_fire, pix_wrap, chan_end, frame_end;

  // Ready is withheld during reset so every output reads 0 while rst is high.
  assign cfg_ready  = (state_q == S_IDLE) && !rst;
  assign bias_ready = (state_q == S_LOAD) && !rst;
  assign up_ready   = (state_q == S_RUN)  && !rst;

  assign bias_fire = bias_valid && bias_ready;
  assign up_fire   = up_valid && up_ready;

  assign cfg_legal = (cfg_chans != '0) &&
                     (cfg_chans <= (DEPTH_NB+1)'(NUM_CH)) &&
                     (cfg_pixels != '0);

  // Indices stop at chan_last, so DEPTH_NB bits cover the full 2**DEPTH_NB range.
  assign pix_wrap  = (pix_cnt_q == pix_last_q);
  assign chan_end  = (chan_idx_q == chan_last_q);
  assign frame_end = pix_wrap && chan_end;

  // Next-state and counter logic for the sequencer.
  always_comb begin
    state_d     = state_q;
    chan_last_d = chan_last_q;
    pix_last_d  = pix_last_q;
    load_idx_d  = load_idx_q;
    chan_idx_d  = chan_idx_q;
    pix_cnt_d   = pix_cnt_q;
    cfg_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          if (cfg_legal) begin
            // cfg_chans == 2**DEPTH_NB has zero low bits; minus one wraps to all ones.
            chan_last_d = cfg_chans[DEPTH_NB-1:0] - DEPTH_NB'(1);
            pix_last_d  = cfg_pixels - CNT_WIDTH'(1);
            load_idx_d  = '0;
            chan_idx_d  = '0;
            pix_cnt_d   = '0;
            state_d     = S_LOAD;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (bias_valid) begin
          load_idx_d = load_idx_q + DEPTH_NB'(1);
          if (load_idx_q == chan_last_q) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (up_valid) begin
          if (pix_wrap) begin
            pix_cnt_d  = '0;
            chan_idx_d = chan_idx_q + DEPTH_NB'(1);
            if (chan_end) state_d = S_IDLE;
          end else begin
            pix_cnt_d = pix_cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer registers; synchronous reset abandons any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      chan_last_q <= '0;
      pix_last_q  <= '0;
      load_idx_q  <= '0;
      chan_idx_q  <= '0;
      pix_cnt_q   <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_last_q <= chan_last_d;
      pix_last_q  <= pix_last_d;
      load_idx_q  <= load_idx_d;
      chan_idx_q  <= chan_idx_d;
      pix_cnt_q   <= pix_cnt_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Bias storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (bias_fire) bias_mem[load_idx_q] <= bias_data;
  end

  // Two-stage valid pipeline, independent of the FSM so a frame drains
  // correctly while the next one is already configuring and loading.
  always_ff @(posedge clk) begin
    if (rst) begin
      add_data_q <= '0;
      add_bias_q <= '0;
      v1_q       <= 1'b0;
      l1_q       <= 1'b0;
      dn_valid_q <= 1'b0;
      dn_last_q  <= 1'b0;
    end else begin
      if (up_fire) begin
        add_data_q <= up_data;
        add_bias_q <= bias_mem[chan_idx_q];
      end
      v1_q       <= up_fire;
      l1_q       <= up_fire && frame_end;
      dn_valid_q <= v1_q;
      dn_last_q  <= l1_q;
    end
  end

  assign add_data = add_data_q;
  assign add_bias = add_bias_q;
  assign dn_valid = dn_valid_q;
  assign dn_last  = dn_last_q;
  assign cfg_err  = cfg_err_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_bias_ctrl.sv
// Bench for bias_ctrl: frame-level reference model with a scoreboard of
// expected bias_add sums, last flags and arrival cycles.
module tb_bias_ctrl;
  localparam int NW = 16;
  localparam int DN = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic [DN:0]   cfg_chans;
  logic [CW-1:0] cfg_pixels;
  logic          cfg_ready, cfg_err;
  logic          bias_valid;
  logic [NW-1:0] bias_data;
  logic          bias_ready;
  logic          up_valid;
  logic [NW-1:0] up_data;
  logic          up_ready;
  logic [NW-1:0] add_bias, add_data;
  logic          dn_valid, dn_last, busy;

  bias_ctrl #(.NUM_WIDTH(NW), .DEPTH_NB(DN), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_chans(cfg_chans), .cfg_pixels(cfg_pixels),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .bias_valid(bias_valid), .bias_data(bias_data), .bias_ready(bias_ready),
    .up_valid(up_valid), .up_data(up_data), .up_ready(up_ready),
    .add_bias(add_bias), .add_data(add_data),
    .dn_valid(dn_valid), .dn_last(dn_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Behavioural stand-in for bias_add: registered wrap-around sum.
  logic [NW-1:0] dn_data_m;
  always @(posedge clk) dn_data_m <= add_data + add_bias;

  typedef struct {
    logic [NW-1:0] sum;
    logic          last;
    int unsigned   at;
  } exp_t;
  exp_t exp_q[$];

  logic [NW-1:0] bias_a [16];
  logic [NW-1:0] data_a [$];

  always @(negedge clk) begin : monitor
    exp_t e;
    if (dn_valid) begin
      if (exp_q.size() == 0) chk("dn_spurious", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("dn_data", {16'd0, dn_data_m}, {16'd0, e.sum});
        chk("dn_last", {31'd0, dn_last}, {31'd0, e.last});
        chk("dn_cycle", cyc, e.at);
      end
    end else if (dn_last) begin
      chk("dn_last_alone", 32'd1, 32'd0);
    end
  end

  // Drives one frame starting at a negedge; returns at the negedge after the
  // final handshake. stop_after >= 0 abandons the stream after that many words.
  task automatic run_frame(input int chans, input int pixels, input int gap, input int stop_after);
    int   n;
    exp_t e;
    n = chans * pixels;
    cfg_valid  = 1'b1;
    cfg_chans  = (DN+1)'(chans);
    cfg_pixels = CW'(pixels);
    chk("cfg_ready", {31'd0, cfg_ready}, 32'd1);
    @(negedge clk);
    cfg_valid = 1'($urandom_range(0, 1));
    cfg_chans = '0;
    for (int i = 0; i < chans; i++) begin
      bias_valid = 1'b1;
      bias_data  = bias_a[i];
      up_valid   = 1'($urandom_range(0, 1));
      up_data    = NW'($urandom);
      chk("bias_ready", {31'd0, bias_ready}, 32'd1);
      chk("cfg_ready_load", {31'd0, cfg_ready}, 32'd0);
      chk("busy_load", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    bias_valid = 1'b0;
    for (int w = 0; w < n; w++) begin
      if (w == stop_after) return;
      if ((gap == 1 && w > 0) || gap == 2) begin
        int idle;
        idle = (gap == 1) ? 1 : $urandom_range(0, 2);
        for (int k = 0; k < idle; k++) begin
          up_valid   = 1'b0;
          up_data    = NW'($urandom);
          bias_valid = 1'($urandom_range(0, 1));
          bias_data  = NW'($urandom);
          chk("up_ready_idle", {31'd0, up_ready}, 32'd1);
          @(negedge clk);
        end
      end
      up_valid   = 1'b1;
      up_data    = data_a[w];
      bias_valid = 1'b0;
      chk("up_ready", {31'd0, up_ready}, 32'd1);
      chk("bias_ready_run", {31'd0, bias_ready}, 32'd0);
      e.sum  = data_a[w] + bias_a[w / pixels];
      e.last = (w == n - 1);
      e.at   = cyc + 2;
      exp_q.push_back(e);
      @(negedge clk);
    end
    up_valid  = 1'b0;
    cfg_valid = 1'b0;
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("cfg_ready_end", {31'd0, cfg_ready}, 32'd1);
  endtask

  task automatic bad_cfg(input int chans, input int pixels);
    cfg_valid  = 1'b1;
    cfg_chans  = (DN+1)'(chans);
    cfg_pixels = CW'(pixels);
    chk("cfg_ready_bad", {31'd0, cfg_ready}, 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("cfg_err", {31'd0, cfg_err}, 32'd1);
    chk("busy_bad", {31'd0, busy}, 32'd0);
    chk("bias_ready_bad", {31'd0, bias_ready}, 32'd0);
    @(negedge clk);
    chk("cfg_err_pulse", {31'd0, cfg_err}, 32'd0);
    chk("bias_ready_bad2", {31'd0, bias_ready}, 32'd0);
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    chk("drain", exp_q.size(), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_dn_valid"}, {31'd0, dn_valid}, 32'd0);
    chk({tag, "_dn_last"}, {31'd0, dn_last}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_cfg_err"}, {31'd0, cfg_err}, 32'd0);
    chk({tag, "_add_data"}, {16'd0, add_data}, 32'd0);
    chk({tag, "_add_bias"}, {16'd0, add_bias}, 32'd0);
    chk({tag, "_readies"}, {29'd0, cfg_ready, bias_ready, up_ready}, 32'd0);
  endtask

  task automatic set_small_frame();
    bias_a[0] = 16'd100;
    bias_a[1] = 16'hFFFB;
    data_a.delete();
    for (int i = 1; i <= 6; i++) data_a.push_back(NW'(i));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int ch, px;
    rst = 1'b1; cfg_valid = 1'b0; cfg_chans = '0; cfg_pixels = '0;
    bias_valid = 1'b0; bias_data = '0; up_valid = 1'b0; up_data = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    #1;
    chk("cfg_ready_after_reset", {31'd0, cfg_ready}, 32'd1);
    @(negedge clk);

    // Basic frame, back-to-back data, then the same frame with alternating gaps.
    set_small_frame();
    run_frame(2, 3, 0, -1);
    drain();
    set_small_frame();
    run_frame(2, 3, 1, -1);
    drain();

    // Illegal configurations.
    bad_cfg(0, 3);
    bad_cfg(17, 3);
    bad_cfg(2, 0);

    // Full depth: 16 channels, one pixel each.
    data_a.delete();
    for (int i = 0; i < 16; i++) begin
      bias_a[i] = NW'(i);
      data_a.push_back(16'd1000);
    end
    run_frame(16, 1, 0, -1);
    drain();

    // Reset in the middle of RUN after two words.
    set_small_frame();
    run_frame(2, 3, 0, 2);
    rst = 1'b1;
    up_valid = 1'b0;
    @(posedge clk);
    #1 exp_q.delete();
    @(negedge clk);
    check_all_zero("midreset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    set_small_frame();
    run_frame(2, 3, 0, -1);
    drain();

    // Single channel, single pixel, followed immediately by another frame.
    bias_a[0] = 16'h7FFF;
    data_a.delete();
    data_a.push_back(16'd1);
    run_frame(1, 1, 0, -1);
    set_small_frame();
    run_frame(2, 3, 0, -1);

    // Randomised frames, back to back, with random gaps and ignored inputs.
    for (int f = 0; f < 6; f++) begin
      ch = $urandom_range(1, 16);
      px = $urandom_range(1, 4);
      for (int i = 0; i < 16; i++) bias_a[i] = NW'($urandom);
      data_a.delete();
      for (int i = 0; i < ch * px; i++) data_a.push_back(NW'($urandom));
      run_frame(ch, px, 2, -1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
